max7219_frame_sequencer: RTL
============================

Name: max7219_frame_sequencer

Overview:
Schedules a playlist of display frames for max7219_cmd_decod. Each frame is a (start_ptr, last_ptr) window in the decoder command RAM plus a hold time. The block stores up to G_NB_FRAMES entries in a local table. It drives the decoder pointer handshake, waits for o_ptr_equality, holds the frame, then advances with optional wrap-around. It sits between the system register bank and max7219_cmd_decod, and owns that decoder's pointer inputs exclusively.

Parameters:
G_RAM_ADDR_WIDTH, 8, width of decoder RAM pointers
G_NB_FRAMES, 8, frame table depth (power of 2, >=2)
G_HOLD_WIDTH, 16, width of per-frame hold count
G_TICK_CYCLES, 1000, clk cycles per hold tick (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_en  in  1  block enable; 0 forces IDLE next cycle
i_start  in  1  pulse: begin playlist at frame 0
i_stop  in  1  pulse: finish current frame, then stop
i_repeat  in  1  1: wrap to frame 0 after last frame; 0: single pass
i_nb_frames  in  log2(G_NB_FRAMES)+1  number of valid frames, 1..G_NB_FRAMES
i_cfg_we  in  1  frame table write strobe
i_cfg_idx  in  log2(G_NB_FRAMES)  table entry written
i_cfg_start_ptr  in  G_RAM_ADDR_WIDTH  entry start pointer
i_cfg_last_ptr  in  G_RAM_ADDR_WIDTH  entry last pointer
i_cfg_hold  in  G_HOLD_WIDTH  entry hold, in ticks
o_start_ptr  out  G_RAM_ADDR_WIDTH  to decoder i_start_ptr
o_last_ptr  out  G_RAM_ADDR_WIDTH  to decoder i_last_ptr
o_ptr_val  out  1  to decoder i_ptr_val, one-cycle pulse
o_loop  out  1  to decoder i_loop, tied 0
i_ptr_equality  in  1  from decoder: frame window fully sent
i_discard  in  1  from decoder: ptr_val rejected
o_busy  out  1  state != IDLE
o_frame_idx  out  log2(G_NB_FRAMES)  frame currently played
o_done  out  1  one-cycle pulse when the playlist ends
o_err  out  1  sticky error flag, cleared by i_start

Behaviour:
- Reset values: all outputs 0; table contents 0; FSM = IDLE; counters 0.
- Table writes happen on any clk with i_cfg_we=1, in any state.
- The entry being played is latched in LOAD, so writes to it take effect on its next play.
- FSM states: IDLE, LOAD, ISSUE, CHECK, WAIT_EQ, HOLD, NEXT.
- IDLE: i_start & i_en -> LOAD. Sets idx=0, stop flag=0, o_err=0.
- LOAD: registers table[idx] onto o_start_ptr/o_last_ptr and the hold count -> ISSUE.
- ISSUE: o_ptr_val=1 for exactly one cycle -> CHECK.
- CHECK (1 cycle, covers decoder discard latency):
  - i_discard=1 -> ISSUE (retry). Retries are unlimited unless the optional feature is compiled in.
  - otherwise -> WAIT_EQ.
- WAIT_EQ: waits for i_ptr_equality=1 -> HOLD. Loads the tick prescaler to G_TICK_CYCLES-1.
- HOLD: prescaler counts down; at 0 it reloads and decrements the hold count.
  - Leaves when the hold count reaches 0 -> NEXT.
  - hold=0 skips HOLD (WAIT_EQ -> NEXT directly).
  - Total HOLD time = hold*G_TICK_CYCLES cycles, ±0.
- NEXT:
  - stop flag=1 -> IDLE, o_done pulse.
  - else if idx==i_nb_frames-1: i_repeat=1 -> idx=0, LOAD; i_repeat=0 -> IDLE, o_done pulse.
  - else idx+1 -> LOAD.
- i_stop while busy sets the stop flag; the current frame completes, then the block goes to IDLE.
- i_start while busy is ignored.
- Simultaneous i_start and i_stop in IDLE: start wins, stop is ignored.
- i_en=0 in any state -> IDLE next cycle. o_ptr_val is forced 0; no o_done pulse; pointers hold their last value.
- i_nb_frames=0 or >G_NB_FRAMES is treated as 1. This also sets o_err at start.
- Asynchronous reset mid-operation: returns immediately to reset values. The table is cleared.
- No arithmetic wrap on idx other than the explicit wrap in NEXT.

Optional Feature:
MAX7219_FRAME_SEQ_TIMEOUT_EN: adds a 32-bit watchdog plus parameter G_TIMEOUT_CYCLES (default 1_000_000).
- The watchdog counts cycles spent in WAIT_EQ.
- Reaching G_TIMEOUT_CYCLES, or more than 3 consecutive discards, sets o_err and goes to IDLE with an o_done pulse.
- Without the macro: the block waits forever in WAIT_EQ, retries without limit, and o_err reports only the nb_frames error.

Decomposition:
- Package max7219_frame_seq_pkg holds:
  - the state enum t_seq_state;
  - the frame record typedef t_frame_entry {start_ptr, last_ptr, hold};
  - the constant C_IDX_WIDTH = $clog2(G_NB_FRAMES) default.
- One sub-module, max7219_tick_timer: prescaler plus hold down-counter, with load/start inputs and an expired output.

Test Plan:
- Write 3 frames: (0,3,2), (4,7,0), (8,15,1). G_TICK_CYCLES=4, i_nb_frames=3, i_repeat=0, i_start. Required response:
  - o_ptr_val pulses with ptrs 0/3, 4/7, 8/15 in order;
  - HOLD lasts exactly 8, 0 and 4 cycles after each i_ptr_equality;
  - o_done pulses once; o_busy=0 afterwards.
- Same setup with i_repeat=1: after frame 2, o_frame_idx=0 and ptrs 0/3 are reissued. Then pulse i_stop during frame 1: frame 1 completes, o_done pulses, and frame 2 is not issued.
- Assert i_discard in the CHECK cycle twice: o_ptr_val is reissued 2 extra times with unchanged ptrs, then normal progress resumes.
- Assert rst_n=0 during HOLD of frame 1: all outputs are 0 within the same cycle, and table entries read back as 0 on the next play.
- Set i_nb_frames=0 and pulse i_start: o_err=1 and exactly one frame (entry 0) plays. With TIMEOUT_EN and no i_ptr_equality: o_err=1 and o_done pulses after G_TIMEOUT_CYCLES.
- Pull i_en low during WAIT_EQ: IDLE next cycle, no o_done. Then i_en=1 with i_start: the playlist restarts at frame 0.

Source files
------------

// File: rtl/max7219_frame_seq_pkg.sv
// Shared types and default sizing for the MAX7219 frame sequencer.
package max7219_frame_seq_pkg;

    localparam int C_RAM_ADDR_WIDTH = 8;
    localparam int C_HOLD_WIDTH     = 16;
    localparam int C_NB_FRAMES      = 8;
    localparam int C_IDX_WIDTH      = $clog2(C_NB_FRAMES);

    // Sequencer states; the value is exported on o_dbg_state.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        CHECK   = 3'd3,
        WAIT_EQ = 3'd4,
        HOLD    = 3'd5,
        NEXT    = 3'd6
    } t_seq_state;

    // One playlist entry at the default widths.
    typedef struct packed {
        logic [C_RAM_ADDR_WIDTH-1:0] start_ptr;
        logic [C_RAM_ADDR_WIDTH-1:0] last_ptr;
        logic [C_HOLD_WIDTH-1:0]     hold;
    } t_frame_entry;

endpackage

// File: rtl/max7219_tick_timer.sv
// Hold timer: a tick prescaler feeding a hold down-counter.
// i_load captures the hold count, i_start arms the prescaler, i_run counts.
// o_expired flags the final cycle of the hold interval.
module max7219_tick_timer #(
    parameter int G_HOLD_WIDTH  = 16,
    parameter int G_TICK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [G_HOLD_WIDTH-1:0] i_hold,
    input  logic                    i_start,
    input  logic                    i_run,
    output logic                    o_zero,
    output logic                    o_expired
);

    localparam int PW = (G_TICK_CYCLES > 1) ? $clog2(G_TICK_CYCLES) : 1;
    localparam logic [PW-1:0] P_RELOAD = PW'(G_TICK_CYCLES - 1);

    logic [PW-1:0]           presc_q;
    logic [G_HOLD_WIDTH-1:0] cnt_q;

    // Prescaler reload/countdown and hold-count decrement on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (i_load) begin
            cnt_q <= i_hold;
        end else if (i_start) begin
            presc_q <= P_RELOAD;
        end else if (i_run) begin
            if (presc_q == '0) begin
                presc_q <= P_RELOAD;
                if (cnt_q != '0) cnt_q <= cnt_q - G_HOLD_WIDTH'(1);
            end else begin
                presc_q <= presc_q - PW'(1);
            end
        end
    end

    assign o_zero    = (cnt_q == '0);
    assign o_expired = i_run && (presc_q == '0) && (cnt_q == G_HOLD_WIDTH'(1));

endmodule

// File: rtl/max7219_frame_sequencer.sv
// Plays a table of (start_ptr, last_ptr, hold) frames through the
// max7219_cmd_decod pointer interface.
// Decoder handshake: o_ptr_val is a one-cycle request carrying
// o_start_ptr/o_last_ptr; the decoder may answer with i_discard in the
// following cycle (request dropped, reissue) and later raises
// i_ptr_equality once the window has been sent.
// Optional build macro MAX7219_FRAME_SEQ_TIMEOUT_EN adds a WAIT_EQ watchdog
// and a limit of 3 consecutive discards.
module max7219_frame_sequencer
    import max7219_frame_seq_pkg::*;
#(
    parameter int G_RAM_ADDR_WIDTH = 8,
    parameter int G_NB_FRAMES      = 8,
    parameter int G_HOLD_WIDTH     = 16,
    parameter int G_TICK_CYCLES    = 1000
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
    , parameter int G_TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_en,
    input  logic                                 i_start,
    input  logic                                 i_stop,
    input  logic                                 i_repeat,
    input  logic [$clog2(G_NB_FRAMES):0]         i_nb_frames,
    input  logic                                 i_cfg_we,
    input  logic [$clog2(G_NB_FRAMES)-1:0]       i_cfg_idx,
    input  logic [G_RAM_ADDR_WIDTH-1:0]          i_cfg_start_ptr,
    input  logic [G_RAM_ADDR_WIDTH-1:0]          i_cfg_last_ptr,
    input  logic [G_HOLD_WIDTH-1:0]              i_cfg_hold,
    output logic [G_RAM_ADDR_WIDTH-1:0]          o_start_ptr,
    output logic [G_RAM_ADDR_WIDTH-1:0]          o_last_ptr,
    output logic                                 o_ptr_val,
    output logic                                 o_loop,
    input  logic                                 i_ptr_equality,
    input  logic                                 i_discard,
    output logic                                 o_busy,
    output logic [$clog2(G_NB_FRAMES)-1:0]       o_frame_idx,
    output logic                                 o_done,
    output logic                                 o_err,
    output t_seq_state                           o_dbg_state
);

    localparam int IW = $clog2(G_NB_FRAMES);
    localparam logic [IW:0] NB_MAX = (IW+1)'(G_NB_FRAMES);

    logic [G_RAM_ADDR_WIDTH-1:0] tbl_start [G_NB_FRAMES];
    logic [G_RAM_ADDR_WIDTH-1:0] tbl_last  [G_NB_FRAMES];
    logic [G_HOLD_WIDTH-1:0]     tbl_hold  [G_NB_FRAMES];

    t_seq_state state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          stop_q, stop_d;
    logic          err_q, err_d;
    logic          done, ptr_val;
    logic          tmr_load, tmr_start, tmr_run, tmr_zero, tmr_expired;
    logic          nb_valid, is_last;
    logic [IW:0]   last_idx;

`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic [1:0]  disc_q, disc_d;
`endif

    // Out-of-range frame counts fall back to a single frame.
    assign nb_valid = (i_nb_frames != '0) && (i_nb_frames <= NB_MAX);
    assign last_idx = nb_valid ? (i_nb_frames - (IW+1)'(1)) : '0;
    assign is_last  = ({1'b0, idx_q} == last_idx);

    // Frame table: written at any time, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G_NB_FRAMES; i++) begin
                tbl_start[i] <= '0;
                tbl_last[i]  <= '0;
                tbl_hold[i]  <= '0;
            end
        end else if (i_cfg_we) begin
            tbl_start[i_cfg_idx] <= i_cfg_start_ptr;
            tbl_last[i_cfg_idx]  <= i_cfg_last_ptr;
            tbl_hold[i_cfg_idx]  <= i_cfg_hold;
        end
    end

    // State, index, flags and the latched pointers of the frame in play.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            o_start_ptr <= '0;
            o_last_ptr  <= '0;
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            disc_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
            wd_q    <= wd_d;
            disc_q  <= disc_d;
`endif
            if (state_q == LOAD && i_en) begin
                o_start_ptr <= tbl_start[idx_q];
                o_last_ptr  <= tbl_last[idx_q];
            end
        end
    end

    // Next-state logic and decoder handshake strobes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        err_d     = err_q;
        done      = 1'b0;
        ptr_val   = 1'b0;
        tmr_load  = 1'b0;
        tmr_start = 1'b0;
        tmr_run   = 1'b0;
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
        disc_d    = disc_q;
`endif
        if (i_stop && state_q != IDLE) stop_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (i_start && i_en) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    err_d   = !nb_valid;
                end
            end
            LOAD: begin
                tmr_load = 1'b1;
                state_d  = ISSUE;
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
                disc_d   = '0;
`endif
            end
            ISSUE: begin
                ptr_val = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (i_discard) begin
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
                    if (disc_q == 2'd3) begin
                        err_d   = 1'b1;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        disc_d  = disc_q + 2'd1;
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end else begin
                    state_d = WAIT_EQ;
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
                    disc_d  = '0;
                    wd_d    = '0;
`endif
                end
            end
            WAIT_EQ: begin
                if (i_ptr_equality) begin
                    if (tmr_zero) begin
                        state_d = NEXT;
                    end else begin
                        tmr_start = 1'b1;
                        state_d   = HOLD;
                    end
                end
`ifdef MAX7219_FRAME_SEQ_TIMEOUT_EN
                else if (wd_q >= 32'(G_TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            HOLD: begin
                tmr_run = 1'b1;
                if (tmr_expired) state_d = NEXT;
            end
            NEXT: begin
                if (stop_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end else if (is_last) begin
                    if (i_repeat) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable wins over everything: drop to IDLE without side effects.
        if (!i_en) begin
            state_d = IDLE;
            idx_d   = idx_q;
            err_d   = err_q;
            done    = 1'b0;
            ptr_val = 1'b0;
        end
    end

    max7219_tick_timer #(
        .G_HOLD_WIDTH  (G_HOLD_WIDTH),
        .G_TICK_CYCLES (G_TICK_CYCLES)
    ) u_tick_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (tmr_load),
        .i_hold    (tbl_hold[idx_q]),
        .i_start   (tmr_start),
        .i_run     (tmr_run),
        .o_zero    (tmr_zero),
        .o_expired (tmr_expired)
    );

    assign o_ptr_val   = ptr_val;
    assign o_done      = done;
    assign o_loop      = 1'b0;
    assign o_busy      = (state_q != IDLE);
    assign o_frame_idx = idx_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule
